// File: rtl/ysyx_22041207_if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, inst} pairs, flushes on redirect.
// Define YSYX_22041207_IFQ_STATS_EN to add the full_cycles / flushed_entries counters.
module ysyx_22041207_if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter int          XLEN     = 64,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [31:0]              if_inst,
  input  logic [XLEN-1:0]          if_pc,
  output logic                     if_ready,
  output logic                     pc_delay,
  input  logic                     redirect,
  output logic                     id_valid,
  output logic [31:0]              id_inst,
  output logic [XLEN-1:0]          id_pc,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef YSYX_22041207_IFQ_STATS_EN
  ,
  output logic [31:0]              full_cycles,
  output logic [31:0]              flushed_entries
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Ready depends only on occupancy, so a full queue never passes a pair through.
  assign if_ready = (count != FULL);
  assign pc_delay = ~if_ready;
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~redirect;
  assign pop      = id_valid & id_ready & ~redirect;

  always_comb begin
    id_inst = NOP_INST;
    id_pc   = '0;
    if (id_valid) begin
      id_inst = inst_mem[rd_ptr];
      id_pc   = pc_mem[rd_ptr];
    end
  end

  // NOTE: storage has no reset; count/id_valid mask stale entries, and leaving it out keeps it RAM-friendly.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef YSYX_22041207_IFQ_STATS_EN
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, flushed_entries} + 33'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cycles     <= '0;
      flushed_entries <= '0;
    end else begin
      if (count == FULL && full_cycles != '1)
        full_cycles <= full_cycles + 32'd1;
      if (redirect)
        flushed_entries <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041207_if_id_queue.sv
// Self-checking bench for ysyx_22041207_if_id_queue: queue-based reference model plus directed/random stimulus.
module tb_ysyx_22041207_if_id_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_valid = 1'b0;
  logic [31:0]       if_inst = '0;
  logic [XLEN-1:0]   if_pc = '0;
  logic              if_ready;
  logic              pc_delay;
  logic              redirect = 1'b0;
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [XLEN-1:0]   id_pc;
  logic              id_ready = 1'b0;
  logic [1:0]        count;
`ifdef YSYX_22041207_IFQ_STATS_EN
  logic [31:0]       full_cycles;
  logic [31:0]       flushed_entries;
`endif

  ysyx_22041207_if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .pc_delay(pc_delay), .redirect(redirect),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_ready(id_ready), .count(count)
`ifdef YSYX_22041207_IFQ_STATS_EN
    , .full_cycles(full_cycles), .flushed_entries(flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of {pc, inst} plus the statistics counters.
  logic [XLEN+31:0] mq[$];
  longint unsigned  m_full, m_flushed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_full    = 0;
      m_flushed = 0;
    end else begin
      if (mq.size() == DEPTH && m_full < 64'hFFFF_FFFF) m_full++;
      if (redirect) begin
        m_flushed = m_flushed + mq.size();
        if (m_flushed > 64'hFFFF_FFFF) m_flushed = 64'hFFFF_FFFF;
        mq.delete();
      end else begin
        automatic bit do_push = if_valid && (mq.size() != DEPTH);
        automatic bit do_pop  = id_ready && (mq.size() != 0);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({if_pc, if_inst});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("count",    64'(count),    64'(mq.size()));
      check("id_valid", 64'(id_valid), 64'(mq.size() != 0));
      check("if_ready", 64'(if_ready), 64'(mq.size() != DEPTH));
      check("pc_delay", 64'(pc_delay), 64'(mq.size() == DEPTH));
      if (mq.size() != 0) begin
        check("id_pc",   id_pc,          mq[0][XLEN+31:32]);
        check("id_inst", 64'(id_inst),   64'(mq[0][31:0]));
      end else begin
        check("id_pc_empty",   id_pc,        64'h0);
        check("id_inst_empty", 64'(id_inst), 64'(NOP));
      end
`ifdef YSYX_22041207_IFQ_STATS_EN
      check("full_cycles",     64'(full_cycles),     m_full);
      check("flushed_entries", 64'(flushed_entries), m_flushed);
`endif
    end
  end

  // Drive one cycle's inputs just after a posedge, then advance to #1 after the next posedge.
  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic redir);
    if_valid = v; if_pc = pc; if_inst = inst; id_ready = rdy; redirect = redir;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check("rst_id_valid", 64'(id_valid), 64'h0);
    check("rst_id_inst",  64'(id_inst),  64'h13);
    check("rst_id_pc",    id_pc,         64'h0);
    check("rst_if_ready", 64'(if_ready), 64'h1);
    check("rst_pc_delay", 64'(pc_delay), 64'h0);
    check("rst_count",    64'(count),    64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset then fill with decode stalled.
    step(1, 64'h8000_0000, 32'h0000_0297, 0, 0);
    check("lat1_id_valid", 64'(id_valid), 64'h1);
    step(1, 64'h8000_0004, 32'h00a0_0513, 0, 0);
    check("fill_count",    64'(count),    64'h2);
    check("fill_if_ready", 64'(if_ready), 64'h0);
    check("fill_pc_delay", 64'(pc_delay), 64'h1);
    check("fill_id_pc",    id_pc,         64'h8000_0000);
    check("fill_id_inst",  64'(id_inst),  64'h0000_0297);
    for (int i = 0; i < 3; i++) step(1, 64'hDEAD_0000, 32'hFFFF_FFFF, 0, 0);
    check("hold_id_pc", id_pc, 64'h8000_0000);

    // Full with simultaneous pop: push rejected.
    step(1, 64'hBAD0_0000, 32'h1111_1111, 1, 0);
    check("fullpop_count",    64'(count),    64'h1);
    check("fullpop_if_ready", 64'(if_ready), 64'h1);
    check("fullpop_id_pc",    id_pc,         64'h8000_0004);
    step(1, 64'h8000_0008, 32'h0000_0093, 0, 0);

    // Flush at count=2 with push and pop requested.
    step(1, 64'hBAD1_0000, 32'h2222_2222, 1, 1);
    check("flush_count",    64'(count),    64'h0);
    check("flush_id_valid", 64'(id_valid), 64'h0);
    check("flush_id_inst",  64'(id_inst),  64'h13);

    // Streaming from empty; 10 push/pop pairs wrap the pointers several times.
    step(1, 64'h8000_1000, 32'h0000_0001, 1, 0);
    check("stream_first_valid", 64'(id_valid), 64'h1);
    for (int i = 1; i <= 10; i++) begin
      step(1, 64'h8000_1000 + 64'(4 * i), 32'(i + 1), 1, 0);
      check("stream_count", 64'(count), 64'h1);
      check("stream_id_pc", id_pc, 64'h8000_1000 + 64'(4 * i));
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, {32'h0, $urandom}, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

    // Async reset between edges with one entry queued.
    step(0, 0, 0, 0, 1);
    step(1, 64'h8000_2000, 32'h0000_0297, 0, 0);
    if_valid = 1'b0;
    check("pre_areset_valid", 64'(id_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_id_valid", 64'(id_valid), 64'h0);
    check("areset_count",    64'(count),    64'h0);
    check("areset_if_ready", 64'(if_ready), 64'h1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stats: 5 edges observed full, then a redirect at count=2.
    step(1, 64'h8000_3000, 32'h0000_0013, 0, 0);
    step(1, 64'h8000_3004, 32'h0000_0013, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 64'h8000_3008, 32'h0000_0013, 0, 0);
    step(1, 64'h8000_3008, 32'h0000_0013, 0, 1);
    check("stats_flush_count", 64'(count), 64'h0);
`ifdef YSYX_22041207_IFQ_STATS_EN
    check("stats_full_cycles",     64'(full_cycles),     64'd5);
    check("stats_flushed_entries", 64'(flushed_entries), 64'd2);
`endif
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
